// File: rtl/wb_cmd_if.sv
// Command/response port and Wishbone classic initiator signals for wb_cmd_master.
// The master modport is the initiator's view; the slave modport is the opposite side.
interface wb_cmd_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic          busy_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_i;
  logic [DW-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    input  wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
    output wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, result on a response port.
// Optional bus-cycle timeout enabled by defining WB_CMD_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_ni,
  wb_cmd_if.master  bus
);
  localparam int unsigned SW = DW / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          busy_q, busy_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
`ifdef WB_CMD_TIMEOUT_EN
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   cnt_q, cnt_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
`ifdef WB_CMD_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid_i && cmd_ready_q) begin
          state_d     = S_BUS;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = bus.cmd_we_i;
          sel_d       = bus.cmd_sel_i;
          adr_d       = bus.cmd_adr_i;
          dat_d       = bus.cmd_dat_i;
`ifdef WB_CMD_TIMEOUT_EN
          cnt_d       = 16'd0;
`endif
        end
      end
      S_BUS: begin
        if (bus.wbm_ack_i) begin
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
`ifdef WB_CMD_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // The current strobe cycle is the last allowed one
          state_d     = S_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + 16'd1;
`endif
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
`ifdef WB_CMD_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
`ifdef WB_CMD_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.busy_o      = busy_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = stb_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
`ifdef WB_CMD_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized transactions
// checked against a transaction-level model of strobe length, latency and response contents.
module tb_wb_cmd_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
`ifdef WB_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_cmd_if #(.AW(AW), .DW(DW)) bus();

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Idle cycles with random spurious acks that must be ignored
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_cyc", 64'(bus.wbm_cyc_o), 64'd0);
      chk("idle_stb", 64'(bus.wbm_stb_o), 64'd0);
      chk("idle_rspv", 64'(bus.rsp_valid_o), 64'd0);
      chk("idle_ready", 64'(bus.cmd_ready_o), 64'd1);
      bus.wbm_ack_i = 1'($urandom_range(0, 1));
      bus.wbm_dat_i = $urandom;
    end
  endtask

  // One complete command/bus/response transaction; expectations come from the transaction model
  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [3:0] sel, input int waits, input int rdy_delay,
                         input logic [DW-1:0] rdata, input bit hold);
    int       exp_n;
    bit       timed_out;
    logic [DW-1:0] exp_dat;
    int       guard;
    timed_out = TO_EN && (waits >= int'(TO));
    exp_n     = timed_out ? int'(TO) : waits + 1;
    exp_dat   = (we || timed_out) ? '0 : rdata;

    bus.wbm_ack_i   = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    guard = 0;
    while (bus.cmd_ready_o !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("accept_timeout", 64'(bus.cmd_ready_o), 64'd1);
    @(posedge clk);

    // Strobe phase: exactly exp_n cycles with stable request fields
    for (int c = 0; c < exp_n; c++) begin
      @(negedge clk);
      if (!hold) bus.cmd_valid_i = 1'b0;
      chk("bus_cyc", 64'(bus.wbm_cyc_o), 64'd1);
      chk("bus_stb", 64'(bus.wbm_stb_o), 64'd1);
      chk("bus_we", 64'(bus.wbm_we_o), 64'(we));
      chk("bus_adr", 64'(bus.wbm_adr_o), 64'(adr));
      chk("bus_sel", 64'(bus.wbm_sel_o), 64'(sel));
      if (we) chk("bus_dat", 64'(bus.wbm_dat_o), 64'(dat));
      chk("bus_ready", 64'(bus.cmd_ready_o), 64'd0);
      chk("bus_busy", 64'(bus.busy_o), 64'd1);
      chk("bus_rspv", 64'(bus.rsp_valid_o), 64'd0);
      bus.wbm_ack_i = (c == waits);
      bus.wbm_dat_i = (c == waits) ? rdata : DW'($urandom);
    end

    // Response phase: held stable until consumed
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    chk("rsp_cyc", 64'(bus.wbm_cyc_o), 64'd0);
    chk("rsp_stb", 64'(bus.wbm_stb_o), 64'd0);
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("rsp_dat", 64'(bus.rsp_dat_o), 64'(exp_dat));
    chk("rsp_err", 64'(bus.rsp_err_o), 64'(timed_out));
    for (int d = 0; d < rdy_delay; d++) begin
      bus.wbm_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("hold_dat", 64'(bus.rsp_dat_o), 64'(exp_dat));
      chk("hold_err", 64'(bus.rsp_err_o), 64'(timed_out));
      chk("hold_ready", 64'(bus.cmd_ready_o), 64'd0);
      chk("hold_cyc", 64'(bus.wbm_cyc_o), 64'd0);
    end
    bus.wbm_ack_i   = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    chk("post_rspv", 64'(bus.rsp_valid_o), 64'd0);
    chk("post_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("post_busy", 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    bit prev_hold;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_ack_i   = 1'b0;
    bus.wbm_dat_i   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.cmd_ready_o), 64'd0);
    chk("rst_rspv", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_cyc", 64'(bus.wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(bus.wbm_stb_o), 64'd0);
    chk("rst_we", 64'(bus.wbm_we_o), 64'd0);
    chk("rst_sel", 64'(bus.wbm_sel_o), 64'd0);
    chk("rst_adr", 64'(bus.wbm_adr_o), 64'd0);
    chk("rst_dat", 64'(bus.wbm_dat_o), 64'd0);
    chk("rst_rdat", 64'(bus.rsp_dat_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(bus.cmd_ready_o), 64'd1);

    // Directed: zero-wait write, 3-wait read, stalled response with command pending
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 0, 32'h0, 1'b0);
    idle_cycles(3);
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 3, 0, 32'hCAFE_F00D, 1'b0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 1, 5, 32'h1357_9BDF, 1'b1);
    run_txn(1'b1, 32'h3000_000C, 32'hDEAD_BEEF, 4'h5, 2, 1, 32'h0, 1'b0);
`ifdef WB_CMD_TIMEOUT_EN
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 20, 2, 32'h1111_2222, 1'b0);
    run_txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, int'(TO) - 1, 0, 32'h3333_4444, 1'b0);
`endif

    // Reset asserted during the second wait state of a read
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h3000_0020;
    @(posedge clk);
    repeat (3) @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("pre_rst_cyc", 64'(bus.wbm_cyc_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'(bus.wbm_cyc_o), 64'd0);
    chk("arst_stb", 64'(bus.wbm_stb_o), 64'd0);
    chk("arst_ready", 64'(bus.cmd_ready_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wbm_ack_i = 1'b1;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    chk("rel2_ready", 64'(bus.cmd_ready_o), 64'd1);
    chk("rel2_rspv", 64'(bus.rsp_valid_o), 64'd0);
    chk("rel2_busy", 64'(bus.busy_o), 64'd0);
    idle_cycles(2);

    // Randomized transactions
    prev_hold = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      if (!prev_hold) idle_cycles($urandom_range(0, 2));
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 4'($urandom),
              TO_EN ? $urandom_range(0, 10) : $urandom_range(0, 4),
              $urandom_range(0, 3), DW'($urandom), h);
      prev_hold = h;
    end
    bus.cmd_valid_i = 1'b0;
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
